// File: rtl/mux16_rr_scheduler_if.sv
// Request/data/grant bundle between the requesting sources and the
// round-robin scheduler that owns the 16:1 mux select.
interface mux16_rr_scheduler_if;
  logic [15:0] req;
  logic [15:0] I;
  logic [15:0] grant;
  logic [3:0]  S;
  logic        valid;
  logic        Y;
  logic        Y_vld;

  modport master (output req, I, input grant, S, valid, Y, Y_vld);
  modport slave  (input req, I, output grant, S, valid, Y, Y_vld);
endinterface

// File: rtl/mux16_rr_scheduler.sv
// Round-robin arbiter sharing a 16:1 single-bit mux among 16 requesters,
// with a per-owner hold limit and a registered, qualified mux output.
//
// state | meaning
// IDLE  | no grant active, waiting for any request
// GRANT | one requester owns the mux select
module mux16_rr_scheduler #(
  parameter int N        = 16,
  parameter int SELW     = 4,
  parameter int MAX_HOLD = 8
) (
  input logic                  clk,
  input logic                  rst,
  mux16_rr_scheduler_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0]      state;
  logic [SELW-1:0] ptr;
  logic [7:0]      hold_cnt;
  logic [N-1:0]    grant_q;
  logic [SELW-1:0] sel_q;
  logic            valid_q;
  logic            y_q;
  logic            y_vld_q;

  logic [SELW-1:0] owner_next;
  logic [SELW-1:0] base;
  logic [SELW-1:0] winner;
  logic            others;

  // Scan downward so the smallest offset from base is the last to win.
  function automatic logic [SELW-1:0] rr_pick(input logic [N-1:0] r,
                                              input logic [SELW-1:0] b);
    logic [SELW-1:0] idx;
    rr_pick = b;
    for (int k = N - 1; k >= 0; k--) begin
      idx = b + SELW'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  always_comb begin
    owner_next = sel_q + SELW'(1);
    others     = |(bus.req & ~grant_q);
    base       = (state == IDLE) ? ptr : owner_next;
    winner     = rr_pick(bus.req, base);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant_q  <= '0;
      sel_q    <= '0;
      valid_q  <= 1'b0;
      y_q      <= 1'b0;
      y_vld_q  <= 1'b0;
    end else begin
      y_q     <= valid_q ? bus.I[sel_q] : 1'b0;
      y_vld_q <= valid_q;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= GRANT;
            grant_q  <= N'(1) << winner;
            sel_q    <= winner;
            valid_q  <= 1'b1;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (!bus.req[sel_q]) begin
            ptr <= owner_next;
            if (others) begin
              grant_q  <= N'(1) << winner;
              sel_q    <= winner;
              hold_cnt <= '0;
            end else begin
              state   <= IDLE;
              grant_q <= '0;
              valid_q <= 1'b0;
            end
          end else if (hold_cnt == HOLD_LAST && others) begin
            ptr      <= owner_next;
            grant_q  <= N'(1) << winner;
            sel_q    <= winner;
            hold_cnt <= '0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.S     = sel_q;
  assign bus.valid = valid_q;
  assign bus.Y     = y_q;
  assign bus.Y_vld = y_vld_q;

endmodule

// File: doc/mux16_rr_scheduler.md
Name: mux16_rr_scheduler

Overview:
- Round-robin scheduler that shares the 16:1 single-bit mux datapath among 16 requesters.
- Arbitrates the request vector and drives the 4-bit mux select `S`.
- Captures the selected input bit into a registered output `Y`, qualified by `Y_vld`.
- Sits between the requesting sources and the downstream serial consumer; the mux select is owned by this block only.

Parameters:
- N, 16, number of requesters / mux inputs; fixed at 16 for this revision.
- SELW, 4, select width, equal to log2(N).
- MAX_HOLD, 8, maximum consecutive grant cycles per requester while another request is pending; legal range 1..255.

Ports:
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  16  request vector; bit k high means requester k wants the mux.
- I  input  16  mux data inputs; bit k is requester k's data.
- grant  output  16  one-hot registered grant; all zero when idle.
- S  output  4  registered mux select; equals the index of the set `grant` bit.
- valid  output  1  high while a grant is active.
- Y  output  1  registered mux output, one cycle after the select.
- Y_vld  output  1  qualifies `Y`; equals `valid` delayed one cycle.

Behaviour:
- Reset (async, rst=1): state IDLE; grant=0, S=0, valid=0, Y=0, Y_vld=0; internal pointer ptr=0, hold_cnt=0.
- Winner search: the first set bit of `req`, scanning from index ptr upward and wrapping 15→0.
- State IDLE:
  - If req==0: stay in IDLE.
  - Else: at the next edge, move to GRANT with grant/S/valid set for the winner, and hold_cnt=0.
- State GRANT, evaluated each edge with current owner g=S:
  - a) req[g]==0 and other requests pending: ptr=g+1 mod 16, re-arbitrate, new grant at this edge (zero idle cycles), hold_cnt=0.
  - b) req[g]==0 and no other request: go to IDLE, grant=0, valid=0, ptr=g+1 mod 16.
  - c) req[g]==1, hold_cnt==MAX_HOLD-1, and another request pending: preempt; ptr=g+1 mod 16, re-arbitrate, hold_cnt=0.
  - d) req[g]==1 otherwise: keep the grant; hold_cnt increments, saturating at MAX_HOLD-1. With no contender, the owner holds indefinitely.
- Datapath:
  - Every edge: Y <= valid ? I[S] : 0, and Y_vld <= valid.
  - Latency from a grant change to the corresponding Y is 1 cycle.
- Simultaneous events:
  - A new request arriving in the same cycle the owner drops is eligible in that arbitration.
  - Requests are sampled only at the edge; a 1-cycle pulse that arrives while another requester owns the grant, and drops before the arbitration, is lost (no latching).
- Invariants:
  - `grant` is always zero or one-hot.
  - S==index(grant) whenever valid=1.
  - S holds its last value when idle.
- Reset mid-grant: all outputs clear asynchronously. After reset release, arbitration restarts from ptr=0.

Test Plan:
- Reset, then req=16'h0000 for 5 cycles -> grant=0, valid=0, Y_vld=0 throughout.
- req=16'h0010, I=16'h0010 -> next edge grant=16'h0010, S=4; one cycle later Y=1, Y_vld=1. Drop req -> valid=0 next edge.
- req=16'h8001 held, MAX_HOLD=8 -> grants alternate bit0 (8 cycles), bit15 (8 cycles), bit0, ... and are never both asserted.
- Owner 3 drops while req=16'h0104 -> next edge S=8 (search from 4), no idle cycle between grants.
- I=16'b0101011011010101, all req=1, MAX_HOLD=1 -> S steps 0,1,...,15,0. Y sequence is 1,0,1,0,1,0,1,1,0,1,1,0,1,0,1,0, each one cycle after its S.
- Assert rst mid-grant with S=9 -> outputs zero immediately. After release with req=16'hFFFF -> first grant S=0.
